// File: rtl/eeprom_pkg.sv
// Shared types and constants for the 24C16-style I2C EEPROM responder.
// State encoding is one-hot; ACK/NACK are the SDA levels seen on the ninth clock.
package eeprom_pkg;

   typedef enum logic [9:0] {
      IDLE      = 10'b00_0000_0001,
      CTRL      = 10'b00_0000_0010,
      CTRL_ACK  = 10'b00_0000_0100,
      ADDR      = 10'b00_0000_1000,
      ADDR_ACK  = 10'b00_0001_0000,
      WDATA     = 10'b00_0010_0000,
      WDATA_ACK = 10'b00_0100_0000,
      RDATA     = 10'b00_1000_0000,
      RDATA_ACK = 10'b01_0000_0000,
      WAIT_STOP = 10'b10_0000_0000
   } state_t;

   localparam logic [3:0] DEV_ID_DEFAULT = 4'b1010;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

endpackage

// File: rtl/eeprom_mem.sv
// Byte-wide storage array for the EEPROM responder.
// Synchronous write, combinational read through the shared address pointer.
module eeprom_mem #(
   parameter int ADDR_W = 11
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);

   logic [7:0] mem_array [2**ADDR_W];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem_array[addr] <= wdata;
      end
   end

   assign rdata = mem_array[addr];

endmodule

// File: rtl/eeprom_rsp.sv
// I2C slave modelling a 24C16-style EEPROM: control byte, word address, sequential
// writes and reads with a wrapping address pointer. SDA is open-drain (0 or z).
module eeprom_rsp
   import eeprom_pkg::*;
#(
   parameter int         ADDR_W      = 11,
   parameter logic [3:0] DEV_ID      = DEV_ID_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SCL,
   inout  wire               SDA,
   output logic              busy,
   output logic              wr_strobe,
   output logic              rd_strobe,
   output logic [ADDR_W-1:0] mem_addr
);

   // Synchronizer flops only track the pins, so they are left out of reset.
   logic scl_sync [SYNC_STAGES];
   logic sda_sync [SYNC_STAGES];

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge CLK) begin
               scl_sync[gi] <= SCL;
               sda_sync[gi] <= SDA;
            end
         end else begin : g_next
            always_ff @(posedge CLK) begin
               scl_sync[gi] <= scl_sync[gi-1];
               sda_sync[gi] <= sda_sync[gi-1];
            end
         end
      end
   endgenerate

   logic scl_s, sda_s, scl_prev_reg, sda_prev_reg;
   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   always_ff @(posedge CLK) begin
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
   end

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_s & ~scl_prev_reg;
   assign scl_fall  = ~scl_s & scl_prev_reg;
   assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
   assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

   state_t            state_reg, state_next;
   logic [3:0]        bit_cnt_reg, bit_cnt_next;
   logic [7:0]        shift_reg, shift_next;
   logic              rw_reg, rw_next;
   logic [2:0]        page_reg, page_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic              sda_oe_reg, sda_oe_next;
   logic              ack_phase_reg, ack_phase_next;
   logic              inc_pending_reg, inc_pending_next;
   logic              busy_reg, busy_next;
   logic              wr_strobe_reg, wr_strobe_next;
   logic              rd_strobe_reg, rd_strobe_next;
   logic              mem_we;
   logic [7:0]        mem_rdata;
   logic [7:0]        rx_byte;

   assign rx_byte = {shift_reg[6:0], sda_s};

   eeprom_mem #(.ADDR_W(ADDR_W)) u_mem (
      .CLK   (CLK),
      .we    (mem_we),
      .addr  (mem_addr_reg),
      .wdata (rx_byte),
      .rdata (mem_rdata)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg       <= IDLE;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         rw_reg          <= RW_WRITE;
         page_reg        <= '0;
         mem_addr_reg    <= '0;
         sda_oe_reg      <= 1'b0;
         ack_phase_reg   <= 1'b0;
         inc_pending_reg <= 1'b0;
         busy_reg        <= 1'b0;
         wr_strobe_reg   <= 1'b0;
         rd_strobe_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         bit_cnt_reg     <= bit_cnt_next;
         shift_reg       <= shift_next;
         rw_reg          <= rw_next;
         page_reg        <= page_next;
         mem_addr_reg    <= mem_addr_next;
         sda_oe_reg      <= sda_oe_next;
         ack_phase_reg   <= ack_phase_next;
         inc_pending_reg <= inc_pending_next;
         busy_reg        <= busy_next;
         wr_strobe_reg   <= wr_strobe_next;
         rd_strobe_reg   <= rd_strobe_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      bit_cnt_next     = bit_cnt_reg;
      shift_next       = shift_reg;
      rw_next          = rw_reg;
      page_next        = page_reg;
      mem_addr_next    = inc_pending_reg ? mem_addr_reg + ADDR_W'(1) : mem_addr_reg;
      sda_oe_next      = sda_oe_reg;
      ack_phase_next   = ack_phase_reg;
      inc_pending_next = 1'b0;
      busy_next        = busy_reg;
      wr_strobe_next   = 1'b0;
      rd_strobe_next   = 1'b0;
      mem_we           = 1'b0;

      unique case (state_reg)
         IDLE: begin
            sda_oe_next = 1'b0;
         end
         CTRL: begin
            if (scl_rise) begin
               shift_next   = rx_byte;
               bit_cnt_next = bit_cnt_reg + 4'd1;
               if (bit_cnt_reg == 4'd7) begin
                  bit_cnt_next = '0;
                  if (rx_byte[7:4] != DEV_ID) begin
                     state_next = WAIT_STOP;
                  end else begin
                     rw_next = rx_byte[0];
                     if (rx_byte[0] == RW_WRITE) begin
                        page_next = rx_byte[3:1];
                     end
                     state_next = CTRL_ACK;
                  end
               end
            end
         end
         // First fall pulls SDA low for the ACK, second fall ends the ninth clock.
         CTRL_ACK: begin
            if (scl_fall) begin
               if (!ack_phase_reg) begin
                  sda_oe_next    = 1'b1;
                  ack_phase_next = 1'b1;
               end else begin
                  ack_phase_next = 1'b0;
                  if (rw_reg == RW_READ) begin
                     shift_next     = {mem_rdata[6:0], 1'b0};
                     sda_oe_next    = ~mem_rdata[7];
                     rd_strobe_next = 1'b1;
                     bit_cnt_next   = 4'd1;
                     state_next     = RDATA;
                  end else begin
                     sda_oe_next = 1'b0;
                     state_next  = ADDR;
                  end
               end
            end
         end
         ADDR, WDATA: begin
            if (scl_rise) begin
               shift_next   = rx_byte;
               bit_cnt_next = bit_cnt_reg + 4'd1;
               if (bit_cnt_reg == 4'd7) begin
                  bit_cnt_next = '0;
                  if (state_reg == ADDR) begin
                     mem_addr_next = ADDR_W'({page_reg, rx_byte});
                     state_next    = ADDR_ACK;
                  end else begin
                     mem_we           = 1'b1;
                     wr_strobe_next   = 1'b1;
                     inc_pending_next = 1'b1;
                     state_next       = WDATA_ACK;
                  end
               end
            end
         end
         ADDR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
               if (!ack_phase_reg) begin
                  sda_oe_next    = 1'b1;
                  ack_phase_next = 1'b1;
               end else begin
                  sda_oe_next    = 1'b0;
                  ack_phase_next = 1'b0;
                  state_next     = WDATA;
               end
            end
         end
         // shift_reg[7] always holds the next bit to present on SDA.
         RDATA: begin
            if (scl_fall) begin
               if (bit_cnt_reg == 4'd8) begin
                  sda_oe_next  = 1'b0;
                  bit_cnt_next = '0;
                  state_next   = RDATA_ACK;
               end else begin
                  sda_oe_next  = ~shift_reg[7];
                  shift_next   = {shift_reg[6:0], 1'b0};
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end
            end
         end
         RDATA_ACK: begin
            if (scl_rise && !ack_phase_reg) begin
               if (sda_s == NACK) begin
                  state_next = WAIT_STOP;
               end else begin
                  mem_addr_next  = mem_addr_reg + ADDR_W'(1);
                  ack_phase_next = 1'b1;
               end
            end else if (scl_fall && ack_phase_reg) begin
               shift_next     = {mem_rdata[6:0], 1'b0};
               sda_oe_next    = ~mem_rdata[7];
               rd_strobe_next = 1'b1;
               bit_cnt_next   = 4'd1;
               ack_phase_next = 1'b0;
               state_next     = RDATA;
            end
         end
         WAIT_STOP: begin
            sda_oe_next = 1'b0;
         end
         default: begin
            state_next  = IDLE;
            sda_oe_next = 1'b0;
         end
      endcase

      if (stop_det) begin
         state_next     = IDLE;
         busy_next      = 1'b0;
         sda_oe_next    = 1'b0;
         ack_phase_next = 1'b0;
         mem_we         = 1'b0;
         wr_strobe_next = 1'b0;
         rd_strobe_next = 1'b0;
      end
      if (start_det) begin
         state_next     = CTRL;
         bit_cnt_next   = '0;
         busy_next      = 1'b1;
         sda_oe_next    = 1'b0;
         ack_phase_next = 1'b0;
         mem_we         = 1'b0;
         wr_strobe_next = 1'b0;
         rd_strobe_next = 1'b0;
      end
      if (RESET) begin
         mem_we = 1'b0;
      end
   end

   assign SDA       = sda_oe_reg ? ACK : 1'bz;
   assign busy      = busy_reg;
   assign wr_strobe = wr_strobe_reg;
   assign rd_strobe = rd_strobe_reg;
   assign mem_addr  = mem_addr_reg;

endmodule

// File: tb/tb_eeprom_rsp.sv
// Directed bench for eeprom_rsp: a bit-banged I2C master drives byte writes,
// random/sequential reads, wrong device ID, STOP abort and mid-transfer reset.
module tb_eeprom_rsp;

   localparam int Q = 4;  // CLK cycles per quarter SCL period

   logic        CLK;
   logic        RESET;
   logic        SCL;
   logic        tb_sda_low;
   wire         sda_bus;
   logic        busy, wr_strobe, rd_strobe;
   logic [10:0] mem_addr;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt   = 0;
   int rd_cnt   = 0;

   assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   eeprom_rsp dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .SCL       (SCL),
      .SDA       (sda_bus),
      .busy      (busy),
      .wr_strobe (wr_strobe),
      .rd_strobe (rd_strobe),
      .mem_addr  (mem_addr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (wr_strobe) wr_cnt++;
      if (rd_strobe) rd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic quarter();
      repeat (Q) @(negedge CLK);
   endtask

   // Works both from idle (SCL high) and as a repeated START (SCL low).
   task automatic i2c_start();
      tb_sda_low = 1'b0;
      quarter();
      SCL = 1'b1;
      quarter();
      tb_sda_low = 1'b1;
      quarter();
      SCL = 1'b0;
      quarter();
   endtask

   task automatic i2c_stop();
      tb_sda_low = 1'b1;
      quarter();
      SCL = 1'b1;
      quarter();
      tb_sda_low = 1'b0;
      quarter();
      quarter();
   endtask

   task automatic send_bit(input logic b);
      tb_sda_low = ~b;
      quarter();
      SCL = 1'b1;
      quarter();
      quarter();
      SCL = 1'b0;
      quarter();
   endtask

   task automatic read_bit(output logic b);
      tb_sda_low = 1'b0;
      quarter();
      SCL = 1'b1;
      quarter();
      b = sda_bus;
      quarter();
      SCL = 1'b0;
      quarter();
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      read_bit(ack);
   endtask

   task automatic rd_byte(output logic [7:0] b, input logic mack);
      logic bt;
      for (int i = 7; i >= 0; i--) begin
         read_bit(bt);
         b[i] = bt;
      end
      send_bit(mack);
   endtask

   task automatic rand_read(input logic [7:0] ctrl_w, input logic [7:0] addr,
                            output logic [7:0] data, output logic acks);
      logic a;
      acks = 1'b0;
      i2c_start();
      wr_byte(ctrl_w, a);          acks |= a;
      wr_byte(addr, a);            acks |= a;
      i2c_start();
      wr_byte(ctrl_w | 8'h01, a);  acks |= a;
      rd_byte(data, 1'b1);
      i2c_stop();
   endtask

   logic [7:0] d, d2;
   logic       a, acc;
   int         w0, r0;

   initial begin
      SCL = 1'b1;
      tb_sda_low = 1'b0;
      RESET = 1'b1;
      repeat (10) @(negedge CLK);
      RESET = 1'b0;
      repeat (10) @(negedge CLK);
      check("rst_busy", busy, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wr_strobe", wr_strobe, 0);
      check("rst_rd_strobe", rd_strobe, 0);
      check("rst_sda", sda_bus, 1);

      // Byte write 0x3E to 0x25C
      w0 = wr_cnt;
      i2c_start();
      wr_byte(8'hA4, a); acc = a;
      wr_byte(8'h5C, a); acc |= a;
      wr_byte(8'h3E, a); acc |= a;
      check("bw_acks", acc, 0);
      check("bw_busy", busy, 1);
      i2c_stop();
      check("bw_busy_off", busy, 0);
      check("bw_wr_cnt", wr_cnt - w0, 1);
      check("bw_ptr", mem_addr, 11'h25D);

      // Random read from 0x25C
      w0 = wr_cnt; r0 = rd_cnt;
      rand_read(8'hA4, 8'h5C, d, acc);
      check("rr_acks", acc, 0);
      check("rr_data", d, 8'h3E);
      check("rr_rd_cnt", rd_cnt - r0, 1);
      check("rr_wr_cnt", wr_cnt - w0, 0);
      check("rr_ptr", mem_addr, 11'h25C);
      check("rr_busy_off", busy, 0);

      // Sequential write across the top of the array
      w0 = wr_cnt;
      i2c_start();
      wr_byte(8'hAE, a); acc = a;
      wr_byte(8'hFF, a); acc |= a;
      wr_byte(8'h11, a); acc |= a;
      wr_byte(8'h22, a); acc |= a;
      i2c_stop();
      check("sw_acks", acc, 0);
      check("sw_wr_cnt", wr_cnt - w0, 2);
      check("sw_ptr_wrap", mem_addr, 11'h001);

      // Sequential read back from 0x7FF with master ACK then NACK
      r0 = rd_cnt;
      i2c_start();
      wr_byte(8'hAE, a); acc = a;
      wr_byte(8'hFF, a); acc |= a;
      i2c_start();
      wr_byte(8'hAF, a); acc |= a;
      rd_byte(d, 1'b0);
      rd_byte(d2, 1'b1);
      i2c_stop();
      check("sr_acks", acc, 0);
      check("sr_data0", d, 8'h11);
      check("sr_data1", d2, 8'h22);
      check("sr_rd_cnt", rd_cnt - r0, 2);
      check("sr_ptr", mem_addr, 11'h000);

      // Wrong device ID
      w0 = wr_cnt; r0 = rd_cnt;
      i2c_start();
      wr_byte(8'h54, a);
      check("id_nack", a, 1);
      wr_byte(8'hA0, a);
      check("id_ignored", a, 1);
      check("id_busy", busy, 1);
      check("id_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
      i2c_stop();
      check("id_busy_off", busy, 0);

      // STOP after four data bits leaves the array untouched
      i2c_start();
      wr_byte(8'hA0, a); acc = a;
      wr_byte(8'h10, a); acc |= a;
      wr_byte(8'h5A, a); acc |= a;
      i2c_stop();
      w0 = wr_cnt;
      i2c_start();
      wr_byte(8'hA0, a); acc |= a;
      wr_byte(8'h10, a); acc |= a;
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      i2c_stop();
      check("ab_acks", acc, 0);
      check("ab_wr_cnt", wr_cnt - w0, 0);
      check("ab_busy_off", busy, 0);
      rand_read(8'hA0, 8'h10, d, acc);
      check("ab_readback", d, 8'h5A);

      // Reset in the middle of the address byte
      i2c_start();
      wr_byte(8'hA0, a);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      tb_sda_low = 1'b0;
      check("rs_busy_pre", busy, 1);
      RESET = 1'b1;
      @(negedge CLK);
      check("rs_busy", busy, 0);
      check("rs_sda", sda_bus, 1);
      check("rs_ptr", mem_addr, 0);
      RESET = 1'b0;
      SCL = 1'b1;
      quarter();
      quarter();

      // Write 0x96 to 0x123 and read it back
      i2c_start();
      wr_byte(8'hA2, a); acc = a;
      wr_byte(8'h23, a); acc |= a;
      wr_byte(8'h96, a); acc |= a;
      i2c_stop();
      check("it_wr_acks", acc, 0);
      rand_read(8'hA2, 8'h23, d, acc);
      check("it_rd_acks", acc, 0);
      check("it_data", d, 8'h96);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
